// File: rtl/future_mux_pkg.sv
// future_mux_pkg: mode encodings and per-bit result function shared by the mux pipeline
package future_mux_pkg;
  typedef enum logic [1:0] {
    MODE_SEL   = 2'b00,
    MODE_BLEND = 2'b01,
    MODE_XOR   = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;
  function automatic logic res_bit(input mode_e mode, input logic chs, input logic c0, input logic c1, input logic m);
    return mode == MODE_BLEND ? (m ? c0 : c1) : mode == MODE_XOR ? chs ^ m : mode == MODE_SEL ? chs : 1'b0;
  endfunction
endpackage

// File: rtl/mux_skid_fifo2.sv
// mux_skid_fifo2: two-entry valid/ready buffer with registered ready and zeroed idle output
module mux_skid_fifo2 #(
  parameter int DW = 65
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid_i,
  output logic          push_ready_o,
  input  logic [DW-1:0] push_data_i,
  output logic          pop_valid_o,
  input  logic          pop_ready_i,
  output logic [DW-1:0] pop_data_o
);
  logic [DW-1:0] mem_q [2];
  logic          wptr_q, rptr_q, rdy_q, push, pop;
  logic [1:0]    cnt_q, cnt_d;
  assign push         = push_valid_i & rdy_q;
  assign pop          = pop_valid_o & pop_ready_i;
  assign cnt_d        = cnt_q + {1'b0, push} - {1'b0, pop};
  assign push_ready_o = rdy_q;
  assign pop_valid_o  = cnt_q != 2'd0;
  assign pop_data_o   = pop_valid_o ? mem_q[rptr_q] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= cnt_d != 2'd2;
      if (push) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
    end
  end
endmodule

// File: rtl/mux_nx1_sel_pipe.sv
// mux_nx1_sel_pipe: NUM_CH-way select/blend/xor mux with buffered valid/ready output and transfer counter
module mux_nx1_sel_pipe
  import future_mux_pkg::*;
#(
  parameter int  WIDTH  = 64,
  parameter int  NUM_CH = 4,
  parameter int  CNT_W  = 16,
  localparam int SEL_W  = NUM_CH > 2 ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0]        in_mask,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic [CNT_W-1:0]        xfer_cnt
);
  mode_e            mode;
  logic [WIDTH-1:0] chs, res;
  logic             err;
  logic [CNT_W-1:0] xfer_cnt_q;
  assign mode     = mode_e'(in_mode);
  assign xfer_cnt = xfer_cnt_q;
  always_comb begin
    chs = '0;
    for (int i = 0; i < NUM_CH; i++)
      chs = in_sel == SEL_W'(i) ? in_data[(NUM_CH-1-i)*WIDTH +: WIDTH] : chs;
    err = mode == MODE_RSVD || (mode != MODE_BLEND && {1'b0, in_sel} >= (SEL_W+1)'(NUM_CH));
    res = '0;
    for (int i = 0; i < WIDTH; i++)
      res[i] = !err && res_bit(mode, chs[i], in_data[(NUM_CH-1)*WIDTH+i], in_data[(NUM_CH-2)*WIDTH+i], in_mask[i]);
  end
  mux_skid_fifo2 #(.DW(WIDTH + 1)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_valid_i(in_valid),
    .push_ready_o(in_ready),
    .push_data_i ({err, res}),
    .pop_valid_o (out_valid),
    .pop_ready_i (out_ready),
    .pop_data_o  ({out_err, out_data})
  );
  always_ff @(posedge clk) begin
    if (rst) xfer_cnt_q <= '0;
    else if (out_valid && out_ready) xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
  end
endmodule

// File: tb/tb_mux_nx1_sel_pipe.sv
// tb_mux_nx1_sel_pipe: scoreboard bench for the mux pipeline (4-channel/4-bit counter and 3-channel builds)
module tb_mux_nx1_sel_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic         in_valid, in_ready, out_valid, out_ready, out_err;
  logic [255:0] in_data;
  logic [63:0]  in_mask, out_data;
  logic [1:0]   in_sel, in_mode;
  logic [3:0]   xfer_cnt;
  logic         in_valid3, in_ready3, out_valid3, out_ready3, out_err3;
  logic [191:0] in_data3;
  logic [63:0]  in_mask3, out_data3;
  logic [1:0]   in_sel3, in_mode3;
  logic [15:0]  xfer_cnt3;
  mux_nx1_sel_pipe #(.WIDTH(64), .NUM_CH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mask(in_mask), .in_sel(in_sel), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err), .xfer_cnt(xfer_cnt)
  );
  mux_nx1_sel_pipe #(.WIDTH(64), .NUM_CH(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .in_mask(in_mask3), .in_sel(in_sel3), .in_mode(in_mode3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_data(out_data3), .out_err(out_err3), .xfer_cnt(xfer_cnt3)
  );
  int          n_vec = 0;
  int          n_err = 0;
  int          stalls = 0;
  int          n_xfer = 0;
  logic [3:0]  exp_cnt = 4'd0;
  logic [64:0] sb [$];
  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [64:0] model(input logic [255:0] d, input logic [63:0] m, input int sel, input logic [1:0] mode, input int nch);
    logic [63:0] c0, c1, cs;
    c0 = d[(nch-1)*64 +: 64];
    c1 = d[(nch-2)*64 +: 64];
    cs = sel < nch ? d[(nch-1-sel)*64 +: 64] : 64'd0;
    if (mode == 2'b11 || (mode != 2'b01 && sel >= nch)) return {1'b1, 64'd0};
    if (mode == 2'b01) return {1'b0, (m & c0) | (~m & c1)};
    if (mode == 2'b10) return {1'b0, cs ^ m};
    return {1'b0, cs};
  endfunction
  task automatic send(input logic [255:0] d, input logic [63:0] m, input logic [1:0] sel, input logic [1:0] mode);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    in_sel   = sel;
    in_mode  = mode;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      stalls++;
      t++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", {64'b0, in_ready}, 65'd1);
    else sb.push_back(model(d, m, int'(sel), mode, 4));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      t++;
      @(negedge clk);
    end
    check("drain_timeout", 65'(sb.size()), 65'd0);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (!out_valid) check("idle_zero", {out_err, out_data}, 65'd0);
      else if (out_ready) begin
        if (sb.size() == 0) check("spurious_valid", {64'b0, out_valid}, 65'd0);
        else begin
          check("out", {out_err, out_data}, sb.pop_front());
          check("xfer_cnt", {61'b0, xfer_cnt}, {61'b0, exp_cnt});
          exp_cnt = exp_cnt + 4'd1;
          n_xfer++;
        end
      end
    end
  end
  logic [255:0] t1, d2, da, db, dc;
  logic [1:0]   s3 [5] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
  logic [1:0]   m3 [5] = '{2'd0, 2'd0, 2'd3, 2'd2, 2'd2};
  int           st0;
  initial begin
    in_valid = 0; in_data = '0; in_mask = '0; in_sel = '0; in_mode = '0; out_ready = 0;
    in_valid3 = 0; in_data3 = '0; in_mask3 = '0; in_sel3 = '0; in_mode3 = '0; out_ready3 = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", {64'b0, out_valid}, 65'd0);
    check("rst_data", {out_err, out_data}, 65'd0);
    check("rst_ready", {64'b0, in_ready}, 65'd1);
    check("rst_cnt", {61'b0, xfer_cnt}, 65'd0);
    out_ready = 1'b1;
    t1 = {64'h4384_7844_1712_0101, 64'h5584_7844_1712_0101, 64'h0, 64'h0};
    send(t1, '1, 2'd0, 2'b01);
    check("latency_valid", {64'b0, out_valid}, 65'd1);
    @(posedge clk);
    #1 check("xfer_after_one", {61'b0, xfer_cnt}, 65'd1);
    send(t1, 64'h0, 2'd0, 2'b01);
    send(t1, 64'hFF00_0000_0000_0000, 2'd0, 2'b01);
    d2 = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_0001};
    send(d2, 64'hFFFF_0000_FFFF_0000, 2'd2, 2'b10);
    send(d2, 64'h1234, 2'd3, 2'b00);
    send(d2, 64'h0, 2'd0, 2'b11);
    send(d2, 64'h0, 2'd1, 2'b00);
    drain();
    out_ready = 1'b0;
    da = {4{64'hAAAA_0000_0000_000A}};
    db = {4{64'hBBBB_0000_0000_000B}};
    dc = {4{64'hCCCC_0000_0000_000C}};
    send(da, 64'h0, 2'd1, 2'b00);
    send(db, 64'h0, 2'd2, 2'b00);
    repeat (2) begin
      @(negedge clk);
      check("bp_in_ready", {64'b0, in_ready}, 65'd0);
      check("bp_hold", {out_valid, out_data}, {1'b1, 64'hAAAA_0000_0000_000A});
    end
    st0 = stalls;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    send(dc, 64'h0, 2'd3, 2'b00);
    check("bp_c_held", {64'b0, stalls > st0}, 65'd1);
    drain();
    st0 = stalls;
    for (int i = 0; i < 20; i++)
      send({64'(4*i), 64'(4*i+1), 64'(4*i+2), 64'(4*i+3)}, {$urandom, $urandom}, 2'(i), 2'(i % 3));
    check("stream_stalls", 65'(stalls - st0), 65'd0);
    check("stream_backlog", 65'(sb.size()), 65'd1);
    drain();
    out_ready = 1'b0;
    send(da, 64'h0, 2'd0, 2'b00);
    send(db, 64'h0, 2'd0, 2'b00);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    exp_cnt = 4'd0;
    check("rst2_valid", {64'b0, out_valid}, 65'd0);
    check("rst2_data", {out_err, out_data}, 65'd0);
    check("rst2_ready", {64'b0, in_ready}, 65'd1);
    check("rst2_cnt", {61'b0, xfer_cnt}, 65'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++)
      send({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 2'(i), 2'(i % 4));
    drain();
    check("cnt_wrap", {61'b0, xfer_cnt}, 65'd1);
    for (int i = 0; i < 5; i++) begin
      in_data3  = {64'h1010_2020_3030_4040, 64'h5050_6060_7070_8080, 64'h9090_A0A0_B0B0_C0C0};
      in_mask3  = 64'hF0F0_F0F0_0F0F_0F0F;
      in_sel3   = s3[i];
      in_mode3  = m3[i];
      in_valid3 = 1'b1;
      @(posedge clk);
      #1 in_valid3 = 1'b0;
      check("nch3_valid", {64'b0, out_valid3}, 65'd1);
      check("nch3_out", {out_err3, out_data3}, model({64'b0, in_data3}, in_mask3, int'(s3[i]), m3[i], 3));
      @(posedge clk);
      #1;
    end
    check("nch3_cnt", {49'b0, xfer_cnt3}, 65'd5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
